// File: rtl/pe_pkg.sv
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared state and dataflow-mode encodings for the systolic PE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } pe_state_e;

    typedef enum logic {
        MODE_OS = 1'b0,
        MODE_WS = 1'b1
    } pe_mode_e;

endpackage : pe_pkg

`default_nettype wire

// File: rtl/pe_mult_reg.sv
// ============================================================================
//  Module      : pe_mult_reg
//  Description : Registered full-width multiplier stage (DSP inference point).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_mult_reg #(
    parameter int DATA_W   = 16,
    parameter int WEIGHT_W = 16,
    parameter int SIGNED   = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            data,
    input  logic [WEIGHT_W-1:0]          weight,
    output logic [DATA_W+WEIGHT_W-1:0]   product,
    output logic                         product_valid
);

    localparam int PW = DATA_W + WEIGHT_W;

    logic          data_ext_bit;
    logic          weight_ext_bit;
    logic [PW-1:0] data_ext;
    logic [PW-1:0] weight_ext;
    logic [PW-1:0] product_comb;

    // Extending both operands to the full product width makes a plain
    // truncated multiply correct for either signedness.
    assign data_ext_bit   = (SIGNED != 0) ? data[DATA_W-1] : 1'b0;
    assign weight_ext_bit = (SIGNED != 0) ? weight[WEIGHT_W-1] : 1'b0;
    assign data_ext       = {{WEIGHT_W{data_ext_bit}}, data};
    assign weight_ext     = {{DATA_W{weight_ext_bit}}, weight};
    assign product_comb   = data_ext * weight_ext;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            product       <= '0;
            product_valid <= 1'b0;
        end else if (clear) begin
            product_valid <= 1'b0;
        end else begin
            product_valid <= in_valid;
            if (in_valid) begin
                product <= product_comb;
            end
        end
    end

endmodule : pe_mult_reg

`default_nettype wire

// File: rtl/systolic_pe_pipelined.sv
// ============================================================================
//  Module      : systolic_pe_pipelined
//  Description : Pipelined systolic MAC PE with OS/WS dataflow and result drain
//                chain. Define PE_SATURATE_EN for saturating accumulation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_pe_pipelined
    import pe_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int WEIGHT_W = 16,
    parameter int ACC_W    = 40,
    parameter int SIGNED   = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                mode,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [WEIGHT_W-1:0] weight_in,
    input  logic                weight_load,
    input  logic                clear,
    input  logic                drain,
    input  logic [ACC_W-1:0]    result_in,
    input  logic                result_in_valid,
    output logic [DATA_W-1:0]   data_out,
    output logic [WEIGHT_W-1:0] weight_out,
    output logic                out_valid,
    output logic [ACC_W-1:0]    result_out,
    output logic                result_valid,
    output logic                busy,
    output logic                ovf
);

    localparam int PW = DATA_W + WEIGHT_W;

    pe_state_e             state;
    pe_state_e             state_next;
    pe_mode_e              mode_reg;
    pe_mode_e              mode_eff;
    logic [WEIGHT_W-1:0]   weight_reg;
    logic [WEIGHT_W-1:0]   mult_weight;
    logic                  mult_accept;
    logic [PW-1:0]         product;
    logic                  product_valid;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      prod_ext;
    logic [ACC_W-1:0]      acc_sum;
    logic [ACC_W-1:0]      acc_next;
    logic                  sat_event;

    // Neighbour forwarding runs unconditionally so columns can be loaded
    // while the PE is busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= '0;
            weight_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            data_out   <= data_in;
            weight_out <= weight_in;
            out_valid  <= in_valid;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            weight_reg <= '0;
        end else if (weight_load) begin
            weight_reg <= weight_in;
        end
    end

    // The mode input only matters while IDLE; afterwards the latched copy rules.
    assign mode_eff    = (state == IDLE) ? pe_mode_e'(mode) : mode_reg;
    assign mult_weight = (mode_eff == MODE_WS) ? weight_reg : weight_in;
    assign mult_accept = in_valid && !clear &&
                         (((state == IDLE) && !drain) || (state == ACC));

    pe_mult_reg #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W),
        .SIGNED   (SIGNED)
    ) u_mult (
        .clock         (clock),
        .reset_n       (reset_n),
        .clear         (clear),
        .in_valid      (mult_accept),
        .data          (data_in),
        .weight        (mult_weight),
        .product       (product),
        .product_valid (product_valid)
    );

    always_comb begin
        prod_ext = {{(ACC_W-PW){(SIGNED != 0) ? product[PW-1] : 1'b0}}, product};
    end

`ifdef PE_SATURATE_EN
    logic [ACC_W:0] sum_wide;
    logic           ovf_reg;

    always_comb begin
        sat_event = 1'b0;
        if (SIGNED != 0) begin
            sum_wide  = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
            sat_event = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
            if (!sat_event) begin
                acc_sum = sum_wide[ACC_W-1:0];
            end else if (sum_wide[ACC_W]) begin
                acc_sum = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                acc_sum = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            sum_wide  = {1'b0, acc} + {1'b0, prod_ext};
            sat_event = sum_wide[ACC_W];
            acc_sum   = sat_event ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_reg <= 1'b0;
        end else if (clear) begin
            ovf_reg <= 1'b0;
        end else if (product_valid && sat_event) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf = ovf_reg;
`else
    always_comb begin
        sat_event = 1'b0;
        acc_sum   = acc + prod_ext;
    end

    assign ovf = sat_event;
`endif

    assign acc_next = product_valid ? acc_sum : acc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clear || ((state == DRAIN) && !drain)) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (drain) begin
                    state_next = DRAIN;
                end else if (in_valid) begin
                    state_next = ACC;
                end
            end
            ACC:     if (drain) state_next = FLUSH;
            FLUSH:   state_next = DRAIN;
            DRAIN:   if (!drain) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            mode_reg <= MODE_OS;
        end else begin
            state <= state_next;
            if ((state == IDLE) && (state_next == ACC)) begin
                mode_reg <= pe_mode_e'(mode);
            end
        end
    end

    // Entering DRAIN emits this PE's own total; staying in DRAIN passes the
    // upstream chain through with one cycle of latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_out   <= '0;
            result_valid <= 1'b0;
        end else if ((state_next == DRAIN) && (state != DRAIN)) begin
            result_out   <= acc_next;
            result_valid <= 1'b1;
        end else if ((state_next == DRAIN) && (state == DRAIN)) begin
            result_out   <= result_in;
            result_valid <= result_in_valid;
        end else begin
            result_out   <= '0;
            result_valid <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule : systolic_pe_pipelined

`default_nettype wire

// File: tb/tb_systolic_pe_pipelined.sv
// ============================================================================
//  Module      : tb_systolic_pe_pipelined
//  Description : Directed self-checking bench: main PE, 3-PE drain chain and a
//                32-bit accumulator PE for wrap/saturation (PE_SATURATE_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_pe_pipelined;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;

    // main PE
    logic        mode = 1'b0, in_valid = 1'b0, weight_load = 1'b0;
    logic        clear = 1'b0, drain = 1'b0;
    logic [15:0] data_in = '0, weight_in = '0;
    logic [15:0] data_out, weight_out;
    logic        out_valid, result_valid, busy, ovf;
    logic [39:0] result_out;

    // 3-PE chain, ch_res[3] is the unused upstream end
    logic        ch_valid = 1'b0, ch_drain = 1'b0;
    logic [15:0] ch_data [3];
    logic [39:0] ch_res  [4];
    logic        ch_rv   [4];
    logic        ch_busy [3];
    logic        ch_ovf  [3];
    logic        ch_ov   [3];
    logic [15:0] ch_dout [3];
    logic [15:0] ch_wout [3];

    // 32-bit accumulator PE
    logic        sat_valid = 1'b0, sat_drain = 1'b0;
    logic [31:0] sat_res;
    logic        sat_rv, sat_busy, sat_ovf, sat_ov;
    logic [15:0] sat_dout, sat_wout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    systolic_pe_pipelined #(.DATA_W(16), .WEIGHT_W(16), .ACC_W(40), .SIGNED(1)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .mode            (mode),
        .in_valid        (in_valid),
        .data_in         (data_in),
        .weight_in       (weight_in),
        .weight_load     (weight_load),
        .clear           (clear),
        .drain           (drain),
        .result_in       (40'd0),
        .result_in_valid (1'b0),
        .data_out        (data_out),
        .weight_out      (weight_out),
        .out_valid       (out_valid),
        .result_out      (result_out),
        .result_valid    (result_valid),
        .busy            (busy),
        .ovf             (ovf)
    );

    assign ch_res[3] = '0;
    assign ch_rv[3]  = 1'b0;

    generate
        for (genvar k = 0; k < 3; k++) begin : g_chain
            systolic_pe_pipelined #(.DATA_W(16), .WEIGHT_W(16), .ACC_W(40), .SIGNED(1)) u_pe (
                .clock           (clock),
                .reset_n         (reset_n),
                .mode            (1'b0),
                .in_valid        (ch_valid),
                .data_in         (ch_data[k]),
                .weight_in       (16'd1),
                .weight_load     (1'b0),
                .clear           (1'b0),
                .drain           (ch_drain),
                .result_in       (ch_res[k+1]),
                .result_in_valid (ch_rv[k+1]),
                .data_out        (ch_dout[k]),
                .weight_out      (ch_wout[k]),
                .out_valid       (ch_ov[k]),
                .result_out      (ch_res[k]),
                .result_valid    (ch_rv[k]),
                .busy            (ch_busy[k]),
                .ovf             (ch_ovf[k])
            );
        end
    endgenerate

    systolic_pe_pipelined #(.DATA_W(16), .WEIGHT_W(16), .ACC_W(32), .SIGNED(1)) dut_sat (
        .clock           (clock),
        .reset_n         (reset_n),
        .mode            (1'b0),
        .in_valid        (sat_valid),
        .data_in         (16'd32767),
        .weight_in       (16'd32767),
        .weight_load     (1'b0),
        .clear           (1'b0),
        .drain           (sat_drain),
        .result_in       (32'd0),
        .result_in_valid (1'b0),
        .data_out        (sat_dout),
        .weight_out      (sat_wout),
        .out_valid       (sat_ov),
        .result_out      (sat_res),
        .result_valid    (sat_rv),
        .busy            (sat_busy),
        .ovf             (sat_ovf)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        ch_data[0] = 16'd11;
        ch_data[1] = 16'd22;
        ch_data[2] = 16'd33;
        #12;
        check_eq("rst_result", {24'd0, result_out}, 64'd0);
        check_eq("rst_flags", {60'd0, result_valid, busy, out_valid, ovf}, 64'd0);
        check_eq("rst_fwd", {32'd0, data_out, weight_out}, 64'd0);
        reset_n = 1'b1;
        tick();

        // OS: 3*4 + (-2)*5 + 7*(-1) = -5
        mode = 1'b0; in_valid = 1'b1; data_in = 16'd3; weight_in = 16'd4;
        tick();
        check_eq("os_fwd_data", {48'd0, data_out}, 64'd3);
        check_eq("os_fwd_valid", {63'd0, out_valid}, 64'd1);
        check_eq("os_busy", {63'd0, busy}, 64'd1);
        data_in = 16'hFFFE; weight_in = 16'd5;
        tick();
        check_eq("os_fwd_weight", {48'd0, weight_out}, 64'd5);
        data_in = 16'd7; weight_in = 16'hFFFF;
        tick();
        in_valid = 1'b0; drain = 1'b1;
        tick();
        check_eq("os_flush_rv", {63'd0, result_valid}, 64'd0);
        tick();
        check_eq("os_result", {24'd0, result_out}, 64'hFF_FFFF_FFFB);
        check_eq("os_result_valid", {63'd0, result_valid}, 64'd1);
        tick();
        check_eq("os_rv_one_cycle", {63'd0, result_valid}, 64'd0);
        check_eq("os_busy_drain", {63'd0, busy}, 64'd1);
        drain = 1'b0;
        tick();
        check_eq("os_idle", {62'd0, busy, result_valid}, 64'd0);

        // WS: weight 6 latched; 1*6+2*6+3*6 = 36 (load alongside data 3 uses old weight)
        mode = 1'b1; weight_load = 1'b1; weight_in = 16'd6;
        tick();
        weight_load = 1'b0; in_valid = 1'b1; data_in = 16'd1;
        tick();
        data_in = 16'd2; weight_in = 16'd99;
        tick();
        check_eq("ws_fwd_weight", {48'd0, weight_out}, 64'd99);
        data_in = 16'd3; weight_in = 16'd7; weight_load = 1'b1;
        tick();
        check_eq("ws_fwd_weight2", {48'd0, weight_out}, 64'd7);
        in_valid = 1'b0; weight_load = 1'b0; drain = 1'b1;
        tick();
        tick();
        check_eq("ws_result", {24'd0, result_out}, 64'd36);
        check_eq("ws_result_valid", {63'd0, result_valid}, 64'd1);
        drain = 1'b0;
        tick();

        // clear one cycle after in_valid discards the product
        mode = 1'b0; in_valid = 1'b1; data_in = 16'd10; weight_in = 16'd10;
        tick();
        in_valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_idle", {63'd0, busy}, 64'd0);
        drain = 1'b1;
        tick();
        check_eq("clr_result", {24'd0, result_out}, 64'd0);
        check_eq("clr_result_valid", {63'd0, result_valid}, 64'd1);
        clear = 1'b1;
        tick();
        check_eq("clr_beats_drain", {62'd0, busy, result_valid}, 64'd0);
        clear = 1'b0; drain = 1'b0;
        tick();

        // chain: PE0 tail shows 11, 22, 33
        ch_valid = 1'b1;
        tick();
        ch_valid = 1'b0; ch_drain = 1'b1;
        tick();
        tick();
        check_eq("chain_0", {23'd0, ch_rv[0], ch_res[0]}, {23'd0, 1'b1, 40'd11});
        tick();
        check_eq("chain_1", {23'd0, ch_rv[0], ch_res[0]}, {23'd0, 1'b1, 40'd22});
        tick();
        check_eq("chain_2", {23'd0, ch_rv[0], ch_res[0]}, {23'd0, 1'b1, 40'd33});
        tick();
        check_eq("chain_end", {63'd0, ch_rv[0]}, 64'd0);
        ch_drain = 1'b0;
        tick();
        check_eq("chain_idle", {61'd0, ch_busy[0], ch_busy[1], ch_busy[2]}, 64'd0);

        // 3 x 32767^2 in a 32-bit accumulator
        sat_valid = 1'b1;
        tick();
        tick();
        tick();
        sat_valid = 1'b0; sat_drain = 1'b1;
        tick();
        tick();
`ifdef PE_SATURATE_EN
        check_eq("sat_result", {32'd0, sat_res}, 64'h7FFF_FFFF);
        check_eq("sat_ovf", {63'd0, sat_ovf}, 64'd1);
`else
        check_eq("wrap_result", {32'd0, sat_res}, 64'hBFFD_0003);
        check_eq("wrap_ovf", {63'd0, sat_ovf}, 64'd0);
`endif
        check_eq("sat_rv", {63'd0, sat_rv}, 64'd1);
        sat_drain = 1'b0;
        tick();

        // async reset mid-DRAIN
        in_valid = 1'b1; data_in = 16'd5; weight_in = 16'd5;
        tick();
        in_valid = 1'b0; drain = 1'b1;
        tick();
        tick();
        check_eq("rst_pre_result", {24'd0, result_out}, 64'd25);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_result", {24'd0, result_out}, 64'd0);
        check_eq("arst_flags", {61'd0, result_valid, busy, ovf}, 64'd0);
        check_eq("arst_fwd", {32'd0, data_out, weight_out}, 64'd0);
        #2 reset_n = 1'b1;
        tick();
        check_eq("arst_drain_result", {24'd0, result_out}, 64'd0);
        check_eq("arst_drain_valid", {63'd0, result_valid}, 64'd1);
        drain = 1'b0;
        tick();
        check_eq("final_idle", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_systolic_pe_pipelined

`default_nettype wire

// File: doc/systolic_pe_pipelined.md
Name: systolic_pe_pipelined

Overview:
- Next-generation systolic processing element: registered multiply-accumulate with independent operand and accumulator widths, and a selectable signed/unsigned multiply.
- Two dataflow modes: output-stationary (weight streams in) and weight-stationary (weight latched locally).
- Registered neighbour forwarding, so the operand paths carry no combinational chain across the array.
- A drain state machine shifts results out through a row chain.

Parameters:
DATA_W, 16, data operand width
WEIGHT_W, 16, weight operand width
ACC_W, 40, accumulator/result width; must be >= DATA_W+WEIGHT_W
SIGNED, 1, 1 = two's-complement multiply and accumulate; 0 = unsigned

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
mode  in  1  0 = output-stationary, 1 = weight-stationary; sampled only in IDLE
in_valid  in  1  data_in/weight_in valid this cycle
data_in  in  DATA_W  activation from west neighbour
weight_in  in  WEIGHT_W  weight from north neighbour
weight_load  in  1  weight-stationary mode: latch weight_in into the local weight register
clear  in  1  zero the accumulator and abort any operation
drain  in  1  level signal: start/continue result shift-out
result_in  in  ACC_W  result from upstream PE in the chain
result_in_valid  in  1  result_in valid
data_out  out  DATA_W  registered data_in
weight_out  out  WEIGHT_W  registered weight_in
out_valid  out  1  registered in_valid
result_out  out  ACC_W  drained result
result_valid  out  1  result_out valid
busy  out  1  high when not IDLE
ovf  out  1  sticky overflow flag

Behaviour:
- Reset: all outputs 0; state IDLE; accumulator, weight register and pipeline registers 0.
- Forwarding:
  - data_out, weight_out and out_valid take their inputs after 1 cycle, every cycle, regardless of state.
  - Weight forwarding continues in weight-stationary mode so that weights can be loaded down a column.
- Multiply operand:
  - Output-stationary: weight_in.
  - Weight-stationary: the local weight register, written on weight_load.
  - weight_load in the same cycle as in_valid: the multiply uses the old weight.
- MAC pipeline:
  - Stage 1 registers the full-width product (DATA_W+WEIGHT_W) and a product-valid bit.
  - Stage 2 adds the product, sign- or zero-extended per SIGNED, into the accumulator.
  - Total latency from in_valid to accumulator update is 2 cycles; throughput is 1 per cycle.
  - Accumulator arithmetic wraps modulo 2^ACC_W.
- States:
  - IDLE: the first in_valid moves to ACC. mode is latched on that transition.
  - ACC: accumulates. drain=1 moves to FLUSH.
  - FLUSH: exactly 1 cycle. in_valid is ignored; the pending stage-1 product is still accumulated. Next state DRAIN.
  - DRAIN, first cycle: result_out = accumulator, result_valid = 1.
  - DRAIN, following cycles: result_out/result_valid are result_in/result_in_valid registered (1-cycle latency per PE). in_valid is ignored throughout DRAIN.
  - DRAIN exit: drain=0 returns to IDLE with the accumulator zeroed and result_valid = 0.
- clear:
  - Highest priority. On the next edge: accumulator = 0, product-valid = 0 (the in-flight product is discarded), ovf = 0, state = IDLE, result_valid = 0.
  - clear simultaneous with drain: clear wins.
- drain asserted in IDLE: goes directly to DRAIN and emits the accumulator value (0 after reset or clear).
- Asynchronous reset mid-operation: all state is lost; nothing completes.

Optional Feature:
- Macro: PE_SATURATE_EN.
- Defined:
  - Stage 2 saturates to the ACC_W representable bounds: signed ±(2^(ACC_W-1)) bounds when SIGNED=1; 0 .. 2^ACC_W-1 when SIGNED=0.
  - ovf is set sticky on any saturation event and cleared by clear or reset.
- Undefined: the accumulator wraps and ovf is tied to 0.

Decomposition:
- Package pe_pkg: pe_state_e (IDLE, ACC, FLUSH, DRAIN); pe_mode_e (MODE_OS, MODE_WS).
- Sub-module pe_mult_reg: the registered multiplier stage.
  - Parameters: DATA_W, WEIGHT_W, SIGNED.
  - Outputs: product and product-valid.
  - Isolates vendor DSP inference.

Test Plan:
1. OS mode, SIGNED=1, DATA_W=WEIGHT_W=16. Stream pairs (3,4), (-2,5), (7,-1) with in_valid=1; then drain -> after FLUSH, result_out = -5 with result_valid for 1 cycle; busy=1 until drain is released.
2. WS mode: weight_load with weight_in=6; then stream data 1, 2, 3, with weight_in changing to 99 during the stream -> accumulated result 36. weight_out forwards every weight_in value with 1-cycle latency.
3. clear asserted 1 cycle after in_valid (data 10, weight 10) -> product discarded; a subsequent drain yields 0; state returns to IDLE.
4. Chain of 3 PEs holding 11, 22, 33 (PE0 is the tail). Drain all three -> PE0 result_out shows 11, 22, 33 on consecutive valid cycles.
5. PE_SATURATE_EN defined, ACC_W=32, SIGNED=1. Accumulate 32767*32767 repeatedly -> result clamps at 2147483647 and ovf=1. Without the macro, the result wraps negative and ovf=0.
6. reset_n pulsed low mid-DRAIN -> all outputs 0 immediately, busy=0, and the next drain emits 0.
